// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store engine.
package mem_pkg;

  // Access size encodings as delivered by the MEM-stage decode
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // SPLIT_MODE settings
  localparam int unsigned SPLIT_TRAP = 0;
  localparam int unsigned SPLIT_ON   = 1;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StResp,
    StDrain
  } memState_t;

  // Number of bytes touched by an access of the given size
  function automatic int unsigned sizeBytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables for both beats, store lane shift,
// and load merge / shift / extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic [1:0]                  size,
  input  logic                        isSigned,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W-1:0]           rdataLo,
  input  logic [DATA_W-1:0]           rdataHi,
  output logic [DATA_W/8-1:0]         be0,
  output logic [DATA_W/8-1:0]         be1,
  output logic [DATA_W-1:0]           wdata0,
  output logic [DATA_W-1:0]           wdata1,
  output logic [DATA_W-1:0]           rdataExt,
  output logic                        crosses
);

  localparam int unsigned BYTES = DATA_W / 8;

  int unsigned           nBytes;
  logic [BYTES-1:0]      beMask;
  logic [2*BYTES-1:0]    beWide;
  logic [DATA_W-1:0]     wdMasked;
  logic [2*DATA_W-1:0]   wdWide;
  logic [DATA_W-1:0]     rdShift;
  logic                  signBit;

  // Byte enables and store data, viewed as a two-beat-wide window shifted by off
  always_comb begin
    nBytes   = sizeBytes(size);
    beMask   = '0;
    wdMasked = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i < nBytes) begin
        beMask[i]           = 1'b1;
        wdMasked[8*i +: 8]  = wdata[8*i +: 8];
      end
    end
    beWide  = {{BYTES{1'b0}}, beMask} << off;
    wdWide  = {{DATA_W{1'b0}}, wdMasked} << {off, 3'b000};
    be0     = beWide[BYTES-1:0];
    be1     = beWide[2*BYTES-1:BYTES];
    wdata0  = wdWide[DATA_W-1:0];
    wdata1  = wdWide[2*DATA_W-1:DATA_W];
    crosses = (32'(off) + nBytes) > BYTES;
  end

  // Merge {beat1, beat0}, right-justify, keep n bytes, then zero/sign fill
  always_comb begin
    rdShift = DATA_W'({rdataHi, rdataLo} >> {off, 3'b000});
    case (size)
      SZ_BYTE: signBit = rdShift[7];
      SZ_HALF: signBit = rdShift[15];
      SZ_WORD: signBit = rdShift[31];
      default: signBit = rdShift[DATA_W-1];
    endcase
    rdataExt = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i < nBytes) rdataExt[8*i +: 8] = rdShift[8*i +: 8];
      else            rdataExt[8*i +: 8] = {8{isSigned & signBit}};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: alignment check, trap or split, and an
// SRAM-like req/addr_ok/data_ok sequencer with one beat outstanding.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned SPLIT_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                flush,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_adel,
  output logic                resp_ades,
  output logic [ADDR_W-1:0]   resp_badvaddr,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  memState_t         state;
  logic              weQ;
  logic              signedQ;
  logic [1:0]        sizeQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] rdata0Q;
  logic [DATA_W-1:0] respRdataQ;
  logic              adelQ;
  logic              adesQ;
  logic [ADDR_W-1:0] badvaddrQ;

  logic [2:0]        alignMask;
  logic              misaligned;
  logic              illegalSize;
  logic              trap;
  logic              killLoad;

  logic [ADDR_W-1:0]  baseAddr;
  logic [ADDR_W-1:0]  beat1Addr;
  logic [BYTES-1:0]   be0;
  logic [BYTES-1:0]   be1;
  logic [DATA_W-1:0]  wdata0;
  logic [DATA_W-1:0]  wdata1;
  logic [DATA_W-1:0]  rdataLo;
  logic [DATA_W-1:0]  rdataExt;
  logic               crosses;

  // Alignment / legality check on the incoming request
  always_comb begin
    case (req_size)
      SZ_BYTE: alignMask = 3'b000;
      SZ_HALF: alignMask = 3'b001;
      SZ_WORD: alignMask = 3'b011;
      default: alignMask = 3'b111;
    endcase
    misaligned  = |(req_addr[2:0] & alignMask);
    illegalSize = (req_size == SZ_DWORD) && (DATA_W == 32);
    trap        = illegalSize || (misaligned && (SPLIT_MODE == SPLIT_TRAP));
  end

  // Only loads can be abandoned; a store is committed once beat0 is accepted
  assign killLoad = flush && !weQ;

  assign baseAddr  = {addrQ[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign beat1Addr = baseAddr + ADDR_W'(BYTES);
  assign rdataLo   = (state == StWait1) ? rdata0Q : bus_rdata;

  mem_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane_align (
    .off     (addrQ[OFF_W-1:0]),
    .size    (sizeQ),
    .isSigned(signedQ),
    .wdata   (wdataQ),
    .rdataLo (rdataLo),
    .rdataHi (bus_rdata),
    .be0     (be0),
    .be1     (be1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .rdataExt(rdataExt),
    .crosses (crosses)
  );

  // Sequencer: request latch, bus beats, flush handling and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      weQ        <= 1'b0;
      signedQ    <= 1'b0;
      sizeQ      <= SZ_BYTE;
      addrQ      <= '0;
      wdataQ     <= '0;
      rdata0Q    <= '0;
      respRdataQ <= '0;
      adelQ      <= 1'b0;
      adesQ      <= 1'b0;
      badvaddrQ  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            weQ        <= req_we;
            signedQ    <= req_signed;
            sizeQ      <= req_size;
            addrQ      <= req_addr;
            wdataQ     <= req_wdata;
            respRdataQ <= '0;
            if (trap) begin
              adelQ     <= ~req_we;
              adesQ     <= req_we;
              badvaddrQ <= req_addr;
              state     <= StResp;
            end else begin
              state <= StReq0;
            end
          end
        end
        StReq0: begin
          // An address accepted together with a load flush still owes a data_ok
          if (bus_addr_ok) state <= killLoad ? StDrain : StWait0;
          else if (flush)  state <= StIdle;
        end
        StWait0: begin
          if (bus_data_ok) begin
            if (killLoad) begin
              state <= StIdle;
            end else if (crosses) begin
              rdata0Q <= bus_rdata;
              state   <= StReq1;
            end else begin
              respRdataQ <= weQ ? '0 : rdataExt;
              state      <= StResp;
            end
          end else if (killLoad) begin
            state <= StDrain;
          end
        end
        StReq1: begin
          if (bus_addr_ok)   state <= killLoad ? StDrain : StWait1;
          else if (killLoad) state <= StIdle;
        end
        StWait1: begin
          if (bus_data_ok) begin
            if (killLoad) begin
              state <= StIdle;
            end else begin
              respRdataQ <= weQ ? '0 : rdataExt;
              state      <= StResp;
            end
          end else if (killLoad) begin
            state <= StDrain;
          end
        end
        StResp: begin
          respRdataQ <= '0;
          adelQ      <= 1'b0;
          adesQ      <= 1'b0;
          badvaddrQ  <= '0;
          state      <= StIdle;
        end
        StDrain: begin
          if (bus_data_ok) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Outputs decoded from state and latched request fields only
  always_comb begin
    req_ready     = (state == StIdle);
    resp_valid    = (state == StResp) && !flush;
    resp_rdata    = respRdataQ;
    resp_adel     = adelQ;
    resp_ades     = adesQ;
    resp_badvaddr = badvaddrQ;
    bus_req       = (state == StReq0) || (state == StReq1);
    bus_wr        = bus_req && weQ;
    bus_addr      = '0;
    bus_be        = '0;
    bus_wdata     = '0;
    if (state == StReq0) begin
      bus_addr  = baseAddr;
      bus_be    = be0;
      bus_wdata = weQ ? wdata0 : '0;
    end else if (state == StReq1) begin
      bus_addr  = beat1Addr;
      bus_be    = be1;
      bus_wdata = weQ ? wdata1 : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit trapping instance, a 32-bit
// split instance and a 64-bit split instance, with the bus driven by hand.
module tb_mem_access_unit;

  logic clk;
  logic rst;

  // Shared 32-bit request fields and bus inputs (instances A and B)
  logic        reqValidA, reqValidB;
  logic        reqWe, reqSigned, flush;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        addrOk, dataOk;
  logic [31:0] busRdata;

  logic        readyA, respValidA, adelA, adesA, busReqA, busWrA;
  logic [31:0] respRdataA, badA, busAddrA, busWdataA;
  logic [3:0]  busBeA;

  logic        readyB, respValidB, adelB, adesB, busReqB, busWrB;
  logic [31:0] respRdataB, badB, busAddrB, busWdataB;
  logic [3:0]  busBeB;

  // 64-bit instance C
  logic        reqValidC;
  logic [63:0] reqAddrC, reqWdataC, busRdataC;
  logic        readyC, respValidC, adelC, adesC, busReqC, busWrC;
  logic [63:0] respRdataC, badC, busAddrC, busWdataC;
  logic [7:0]  busBeC;

  int nChecks;
  int nFail;
  logic [31:0] res;
  logic        gotValid;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MODE(0)) dutA (
    .clk(clk), .rst(rst), .req_valid(reqValidA), .req_ready(readyA), .req_we(reqWe),
    .req_size(reqSize), .req_signed(reqSigned), .req_addr(reqAddr), .req_wdata(reqWdata),
    .flush(flush), .resp_valid(respValidA), .resp_rdata(respRdataA), .resp_adel(adelA),
    .resp_ades(adesA), .resp_badvaddr(badA), .bus_req(busReqA), .bus_wr(busWrA),
    .bus_addr(busAddrA), .bus_be(busBeA), .bus_wdata(busWdataA), .bus_addr_ok(addrOk),
    .bus_data_ok(dataOk), .bus_rdata(busRdata)
  );

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MODE(1)) dutB (
    .clk(clk), .rst(rst), .req_valid(reqValidB), .req_ready(readyB), .req_we(reqWe),
    .req_size(reqSize), .req_signed(reqSigned), .req_addr(reqAddr), .req_wdata(reqWdata),
    .flush(flush), .resp_valid(respValidB), .resp_rdata(respRdataB), .resp_adel(adelB),
    .resp_ades(adesB), .resp_badvaddr(badB), .bus_req(busReqB), .bus_wr(busWrB),
    .bus_addr(busAddrB), .bus_be(busBeB), .bus_wdata(busWdataB), .bus_addr_ok(addrOk),
    .bus_data_ok(dataOk), .bus_rdata(busRdata)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(64), .SPLIT_MODE(1)) dutC (
    .clk(clk), .rst(rst), .req_valid(reqValidC), .req_ready(readyC), .req_we(reqWe),
    .req_size(reqSize), .req_signed(reqSigned), .req_addr(reqAddrC), .req_wdata(reqWdataC),
    .flush(flush), .resp_valid(respValidC), .resp_rdata(respRdataC), .resp_adel(adelC),
    .resp_ades(adesC), .resp_badvaddr(badC), .bus_req(busReqC), .bus_wr(busWrC),
    .bus_addr(busAddrC), .bus_be(busBeC), .bus_wdata(busWdataC), .bus_addr_ok(addrOk),
    .bus_data_ok(dataOk), .bus_rdata(busRdataC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait single-beat load on instance A; returns the RESP-cycle outputs
  task automatic loadA(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] mem, output logic [31:0] data, output logic vld);
    reqAddr = addr; reqSize = size; reqSigned = sgn; reqWe = 1'b0; reqValidA = 1'b1;
    tick();
    reqValidA = 1'b0; addrOk = 1'b1;
    tick();
    addrOk = 1'b0; dataOk = 1'b1; busRdata = mem;
    tick();
    dataOk = 1'b0; busRdata = '0;
    data = respRdataA; vld = respValidA;
    tick();
  endtask

  initial begin
    nChecks = 0; nFail = 0;
    rst = 1'b1; reqValidA = 0; reqValidB = 0; reqValidC = 0;
    reqWe = 0; reqSigned = 0; reqSize = 0; reqAddr = 0; reqWdata = 0; flush = 0;
    addrOk = 0; dataOk = 0; busRdata = 0; reqAddrC = 0; reqWdataC = 0; busRdataC = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    checkEq("rst_ready", readyA, 1);
    checkEq("rst_resp_valid", respValidA, 0);
    checkEq("rst_bus_req", busReqA, 0);
    checkEq("rst_bus_be", busBeA, 0);

    // Misaligned word load traps immediately, no bus activity
    reqAddr = 32'h1002; reqSize = 2'd2; reqWe = 0; reqValidA = 1;
    tick();
    reqValidA = 0;
    checkEq("trap_resp_valid", respValidA, 1);
    checkEq("trap_adel", adelA, 1);
    checkEq("trap_ades", adesA, 0);
    checkEq("trap_badvaddr", badA, 32'h1002);
    checkEq("trap_bus_req", busReqA, 0);
    tick();
    checkEq("trap_ready_back", readyA, 1);
    checkEq("trap_resp_done", respValidA, 0);

    // Misaligned store traps with AdES
    reqAddr = 32'h5001; reqWe = 1; reqValidA = 1;
    tick();
    reqValidA = 0;
    checkEq("ades_flag", adesA, 1);
    checkEq("ades_adel", adelA, 0);
    checkEq("ades_badvaddr", badA, 32'h5001);
    tick();

    // Store half at 0x2002, zero-wait bus
    reqAddr = 32'h2002; reqSize = 2'd1; reqWe = 1; reqWdata = 32'hDEADBEEF; reqValidA = 1;
    tick();
    reqValidA = 0;
    checkEq("st_bus_req", busReqA, 1);
    checkEq("st_bus_wr", busWrA, 1);
    checkEq("st_bus_addr", busAddrA, 32'h2000);
    checkEq("st_bus_be", busBeA, 4'b1100);
    checkEq("st_bus_wdata", busWdataA, 32'hBEEF0000);
    checkEq("st_ready_busy", readyA, 0);
    addrOk = 1;
    tick();
    addrOk = 0; dataOk = 1;
    checkEq("st_wait_no_req", busReqA, 0);
    tick();
    dataOk = 0;
    checkEq("st_resp_valid", respValidA, 1);
    checkEq("st_resp_rdata", respRdataA, 0);
    checkEq("st_resp_ades", adesA, 0);
    tick();
    checkEq("st_ready_back", readyA, 1);

    // Split signed load word at 0x3003 on instance B
    reqAddr = 32'h3003; reqSize = 2'd2; reqWe = 0; reqSigned = 1; reqValidB = 1;
    tick();
    reqValidB = 0;
    checkEq("sp_b0_addr", busAddrB, 32'h3000);
    checkEq("sp_b0_be", busBeB, 4'b1000);
    addrOk = 1;
    tick();
    addrOk = 0; dataOk = 1; busRdata = 32'h80AABBCC;
    tick();
    dataOk = 0; busRdata = 0;
    checkEq("sp_b1_req", busReqB, 1);
    checkEq("sp_b1_addr", busAddrB, 32'h3004);
    checkEq("sp_b1_be", busBeB, 4'b0111);
    addrOk = 1;
    tick();
    addrOk = 0; dataOk = 1; busRdata = 32'h11223344;
    checkEq("sp_resp_early", respValidB, 0);
    tick();
    dataOk = 0; busRdata = 0;
    checkEq("sp_resp_valid", respValidB, 1);
    checkEq("sp_resp_rdata", respRdataB, 32'h22334480);
    tick();

    // Illegal dword on a 32-bit unit traps even in split mode
    reqAddr = 32'h6000; reqSize = 2'd3; reqWe = 0; reqValidB = 1;
    tick();
    reqValidB = 0;
    checkEq("ill_resp_valid", respValidB, 1);
    checkEq("ill_adel", adelB, 1);
    checkEq("ill_bus_req", busReqB, 0);
    tick();

    // Byte / half extension
    loadA(32'h4001, 2'd0, 1'b1, 32'h0000F600, res, gotValid);
    checkEq("lb_signed_valid", gotValid, 1);
    checkEq("lb_signed", res, 32'hFFFFFFF6);
    loadA(32'h4001, 2'd0, 1'b0, 32'h0000F600, res, gotValid);
    checkEq("lb_unsigned", res, 32'h000000F6);
    loadA(32'h4002, 2'd1, 1'b1, 32'h80010000, res, gotValid);
    checkEq("lh_signed", res, 32'hFFFF8001);

    // addr_ok delayed 3 cycles, flush in WAIT0 -> drain without a response
    reqAddr = 32'h7000; reqSize = 2'd2; reqWe = 0; reqSigned = 0; reqValidA = 1;
    tick();
    reqValidA = 0;
    for (int i = 0; i < 3; i++) begin
      checkEq("dly_req_held", busReqA, 1);
      checkEq("dly_addr_held", busAddrA, 32'h7000);
      tick();
    end
    addrOk = 1;
    tick();
    addrOk = 0; flush = 1;
    tick();
    flush = 0;
    checkEq("drain_no_resp", respValidA, 0);
    checkEq("drain_busy", readyA, 0);
    tick();
    checkEq("drain_still_busy", readyA, 0);
    dataOk = 1; busRdata = 32'h12345678;
    tick();
    dataOk = 0; busRdata = 0;
    checkEq("drain_ready_back", readyA, 1);
    checkEq("drain_no_resp_after", respValidA, 0);
    tick();
    checkEq("drain_no_resp_late", respValidA, 0);

    // 64-bit aligned dword at the top of the low region
    reqAddrC = 64'h0FFF_FFFF_FFFF_FFF8; reqSize = 2'd3; reqWe = 0; reqSigned = 1; reqValidC = 1;
    tick();
    reqValidC = 0;
    checkEq("d64_addr", busAddrC, 64'h0FFF_FFFF_FFFF_FFF8);
    checkEq("d64_be", busBeC, 8'hFF);
    addrOk = 1;
    tick();
    addrOk = 0; dataOk = 1; busRdataC = 64'h8123_4567_89AB_CDEF;
    tick();
    dataOk = 0; busRdataC = 0;
    checkEq("d64_resp_valid", respValidC, 1);
    checkEq("d64_resp_rdata", respRdataC, 64'h8123_4567_89AB_CDEF);
    tick();

    // 64-bit crossing dword, reset asserted in WAIT1
    reqAddrC = 64'h0FFF_FFFF_FFFF_FFFC; reqValidC = 1;
    tick();
    reqValidC = 0;
    checkEq("x64_b0_addr", busAddrC, 64'h0FFF_FFFF_FFFF_FFF8);
    checkEq("x64_b0_be", busBeC, 8'hF0);
    addrOk = 1;
    tick();
    addrOk = 0; dataOk = 1; busRdataC = 64'h1111_2222_3333_4444;
    tick();
    dataOk = 0; busRdataC = 0;
    checkEq("x64_b1_addr", busAddrC, 64'h1000_0000_0000_0000);
    checkEq("x64_b1_be", busBeC, 8'h0F);
    addrOk = 1;
    tick();
    addrOk = 0;
    checkEq("x64_wait1_busy", readyC, 0);
    rst = 1;
    #1;
    checkEq("x64_rst_ready", readyC, 1);
    checkEq("x64_rst_resp_valid", respValidC, 0);
    checkEq("x64_rst_bus_req", busReqC, 0);
    checkEq("x64_rst_bus_addr", busAddrC, 0);
    checkEq("x64_rst_bus_be", busBeC, 0);
    checkEq("x64_rst_rdata", respRdataC, 0);
    tick();
    rst = 0;
    tick();
    checkEq("x64_post_rst_idle", respValidC, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
